f8_fetch_queue: RTL

//  Instruction prefetch stage directly upstream of the dual-bank (even/odd byte) program ROM.

---
 rtl/f8_fetch_queue_if.sv | 38 +++
 rtl/f8_fetch_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/f8_fetch_queue_if.sv
// f8_fetch_queue_if
//   Bundles the fetch queue's redirect, ROM and decoder-side signals.
//   slave  : the fetch queue itself (drives ROM addresses and the head window).
//   master : the surrounding core/ROM/decoder (drives redirect, ROM data, consume).
// Signals:
//   redirect, redirect_pc        flush and restart fetch at a new byte PC
//   mem_addr_even/odd            word addresses into the even/odd ROM banks
//   mem_data_even/odd            registered ROM bank data (one cycle after address)
//   out_avail                    bytes held in the FIFO (0..DEPTH)
//   out_byte0/out_byte1, out_pc  head byte pair and the byte PC of out_byte0
//   consume                      bytes taken by the decoder this cycle (0..2)
interface f8_fetch_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic        redirect;
  logic [15:0] redirect_pc;
  logic [14:0] mem_addr_even;
  logic [14:0] mem_addr_odd;
  logic [7:0]  mem_data_even;
  logic [7:0]  mem_data_odd;
  logic [CW-1:0] out_avail;
  logic [7:0]  out_byte0;
  logic [7:0]  out_byte1;
  logic [15:0] out_pc;
  logic [1:0]  consume;

  modport slave (
    input  redirect, redirect_pc, mem_data_even, mem_data_odd, consume,
    output mem_addr_even, mem_addr_odd, out_avail, out_byte0, out_byte1, out_pc
  );

  modport master (
    output redirect, redirect_pc, mem_data_even, mem_data_odd, consume,
    input  mem_addr_even, mem_addr_odd, out_avail, out_byte0, out_byte1, out_pc
  );
endinterface

// File: rtl/f8_fetch_queue.sv
// f8_fetch_queue
//   Instruction prefetch stage in front of a dual-bank (even/odd byte) ROM.
//   Every fetch reads one byte from each bank so two sequential bytes come back
//   from any byte address; they are put into program order and pushed into a
//   small byte FIFO whose head pair and PC are presented to the decoder.
// Ports:
//   clk    clock, all state changes on posedge
//   rst_n  synchronous reset, active low
//   q      f8_fetch_queue_if.slave (redirect, ROM address/data, head window, consume)
module f8_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] RESET_PC = 16'h4000
) (
  input  logic              clk,
  input  logic              rst_n,
  f8_fetch_queue_if.slave   q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   fetch_pc_reg, fetch_pc_next;
  logic [15:0]   out_pc_reg, out_pc_next;
  logic          inflight_reg, inflight_next;
  logic          resp_swap_reg, resp_swap_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic [7:0]    fifo_mem [DEPTH];

  logic          issue;
  logic          push;
  logic [CW+1:0] budget;
  logic [CW-1:0] consume_w;
  logic [CW-1:0] consume_eff;
  logic [7:0]    push_byte0;
  logic [7:0]    push_byte1;

  // Odd start PC: the first byte lives in the odd bank of word a, the second
  // in the even bank of word a+1.
  assign q.mem_addr_odd  = fetch_pc_reg[15:1];
  assign q.mem_addr_even = fetch_pc_reg[15:1] + {14'd0, fetch_pc_reg[0]};

  // Conservative space check: bytes held plus bytes already requested plus
  // this request must fit, ignoring any pop happening this cycle.
  always_comb begin
    budget = {2'b00, count_reg} + (inflight_reg ? (CW+2)'(4) : (CW+2)'(2));
    issue  = !q.redirect && (budget <= (CW+2)'(DEPTH));
  end

  // A response arriving during a redirect belongs to the old stream.
  assign push       = inflight_reg && !q.redirect;
  assign push_byte0 = resp_swap_reg ? q.mem_data_odd  : q.mem_data_even;
  assign push_byte1 = resp_swap_reg ? q.mem_data_even : q.mem_data_odd;

  // consume=3 is meaningless and pops nothing; otherwise clamp to what is held.
  always_comb begin
    consume_w   = CW'(q.consume);
    consume_eff = '0;
    if (q.consume != 2'd3) begin
      consume_eff = (consume_w > count_reg) ? count_reg : consume_w;
    end
  end

  always_comb begin
    fetch_pc_next  = fetch_pc_reg;
    out_pc_next    = out_pc_reg;
    inflight_next  = 1'b0;
    resp_swap_next = resp_swap_reg;
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    if (q.redirect) begin
      fetch_pc_next = q.redirect_pc;
      out_pc_next   = q.redirect_pc;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (issue) begin
        fetch_pc_next  = fetch_pc_reg + 16'd2;
        inflight_next  = 1'b1;
        resp_swap_next = fetch_pc_reg[0];
      end
      rd_ptr_next = rd_ptr_reg + AW'(consume_eff);
      wr_ptr_next = wr_ptr_reg + (push ? AW'(2) : AW'(0));
      count_next  = count_reg + (push ? CW'(2) : CW'(0)) - consume_eff;
      out_pc_next = out_pc_reg + 16'(consume_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg  <= RESET_PC;
      out_pc_reg    <= RESET_PC;
      inflight_reg  <= 1'b0;
      resp_swap_reg <= 1'b0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      fetch_pc_reg  <= fetch_pc_next;
      out_pc_reg    <= out_pc_next;
      inflight_reg  <= inflight_next;
      resp_swap_reg <= resp_swap_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
    end
  end

  // Storage is not reset; count_reg alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr_reg]          <= push_byte0;
      fifo_mem[wr_ptr_reg + AW'(1)] <= push_byte1;
    end
  end

  assign q.out_byte0 = fifo_mem[rd_ptr_reg];
  assign q.out_byte1 = fifo_mem[rd_ptr_reg + AW'(1)];
  assign q.out_avail = count_reg;
  assign q.out_pc    = out_pc_reg;

`ifndef SYNTHESIS
  a_consume_legal: assert property (@(posedge clk) disable iff (!rst_n) q.consume != 2'd3);
`endif
endmodule
